// File: rtl/pc_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_rx_pkg                                                                |
// | Shared types and constants for the PC receive packet decoder.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pc_rx_pkg;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_PRE  = 2'd1,
    S_LEN  = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam logic [31:0] c_resync_word = 32'h416FDC1E;
  localparam logic [31:0] c_magic_word  = 32'hD78C1B74;
  localparam int          c_len_w       = 16;

  // A zero length would underflow the remaining-word counter, so it is rejected here.
  function automatic logic len_in_range(input logic [c_len_w-1:0] n, input int max_words);
    return (n != '0) && ({16'd0, n} <= $unsigned(max_words));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_rx_word_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_rx_word_fetch                                                         |
// | FIFO read pacing, in-flight tracking and one-word payload register.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_rx_word_fetch (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_fifo_output_word,
  input  logic        i_fifo_is_empty_sig,
  output logic        o_read_next_word_cmd,
  output logic [31:0] o_land_word,
  output logic        o_land_valid,
  input  logic        i_land_keep,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  input  logic        i_consume
);

  logic        inflight_q;
  logic        valid_q;
  logic [31:0] word_q;
  logic        w_rd;

  // Only one word is ever held or in flight, so a fetched word always has a home.
  assign w_rd = !i_reset && !i_fifo_is_empty_sig && !inflight_q && (!valid_q || i_consume);

  assign o_read_next_word_cmd = w_rd;
  assign o_land_word          = i_fifo_output_word;
  assign o_land_valid         = inflight_q;
  assign o_word               = word_q;
  assign o_word_valid         = valid_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
    end else begin
      inflight_q <= w_rd;
      if (inflight_q && i_land_keep) begin
        word_q  <= i_fifo_output_word;
        valid_q <= 1'b1;
      end else if (i_consume) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_rx_packet_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_rx_packet_decoder                                                     |
// | RESYNC/MAGIC/length framing FSM forwarding payload over valid/ready.     |
// | Option macro: PC_RX_DECODER_RESYNC_ABORT_EN (RESYNC in payload aborts).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_rx_packet_decoder
  import pc_rx_pkg::*;
#(
  parameter logic [31:0] RESYNC_WORD       = c_resync_word,
  parameter logic [31:0] MAGIC_WORD        = c_magic_word,
  parameter int          MAX_PAYLOAD_WORDS = 4096
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_fifo_output_word,
  input  logic        i_fifo_is_empty_sig,
  output logic        o_read_next_word_cmd,
  output logic        o_start_packet_sig,
  output logic [15:0] o_packet_len,
  output logic [31:0] o_payload_word,
  output logic        o_payload_valid,
  input  logic        i_payload_ready,
  output logic        o_packet_done_sig,
  output logic        o_error_sig
);

  state_t               state_q;
  logic [c_len_w-1:0]   remaining_q;
  logic [c_len_w-1:0]   len_q;
  logic                 start_q;
  logic                 done_q;
  logic                 error_q;

  logic [31:0]          w_land_word;
  logic                 w_land_valid;
  logic [31:0]          w_word;
  logic                 w_word_valid;
  logic                 w_consume;
  logic                 w_abort;
  logic                 w_keep;

`ifdef PC_RX_DECODER_RESYNC_ABORT_EN
  assign w_abort = (state_q == S_DATA) && (w_land_word == RESYNC_WORD);
`else
  assign w_abort = 1'b0;
`endif

  // Only payload words ever enter the output register; framing words are decoded on landing.
  assign w_keep    = (state_q == S_DATA) && !w_abort;
  assign w_consume = w_word_valid && i_payload_ready;

  pc_rx_word_fetch u_fetch (
    .i_clock              (i_clock),
    .i_reset              (i_reset),
    .i_fifo_output_word   (i_fifo_output_word),
    .i_fifo_is_empty_sig  (i_fifo_is_empty_sig),
    .o_read_next_word_cmd (o_read_next_word_cmd),
    .o_land_word          (w_land_word),
    .o_land_valid         (w_land_valid),
    .i_land_keep          (w_keep),
    .o_word               (w_word),
    .o_word_valid         (w_word_valid),
    .i_consume            (w_consume)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_HUNT;
      remaining_q <= '0;
      len_q       <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (w_consume) begin
        remaining_q <= remaining_q - 16'd1;
        if (remaining_q == 16'd1) begin
          done_q  <= 1'b1;
          state_q <= S_HUNT;
        end
      end
      if (w_land_valid) begin
        case (state_q)
          S_HUNT: begin
            if (w_land_word == RESYNC_WORD) state_q <= S_PRE;
          end
          S_PRE: begin
            if (w_land_word == MAGIC_WORD) begin
              state_q <= S_LEN;
            end else if (w_land_word != RESYNC_WORD) begin
              error_q <= 1'b1;
              state_q <= S_HUNT;
            end
          end
          S_LEN: begin
            if (len_in_range(w_land_word[15:0], MAX_PAYLOAD_WORDS)) begin
              len_q       <= w_land_word[15:0];
              remaining_q <= w_land_word[15:0];
              start_q     <= 1'b1;
              state_q     <= S_DATA;
            end else begin
              error_q <= 1'b1;
              state_q <= S_HUNT;
            end
          end
          S_DATA: begin
            if (w_abort) begin
              error_q     <= 1'b1;
              remaining_q <= '0;
              state_q     <= S_PRE;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign o_start_packet_sig = start_q;
  assign o_packet_len       = len_q;
  assign o_payload_word     = w_word;
  assign o_payload_valid    = w_word_valid;
  assign o_packet_done_sig  = done_q;
  assign o_error_sig        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_rx_packet_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_rx_packet_decoder                                                  |
// | Self-checking bench: FIFO model, packet-level reference, table + random. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pc_rx_packet_decoder;

  localparam logic [31:0] RESYNC = 32'h416FDC1E;
  localparam logic [31:0] MAGIC  = 32'hD78C1B74;
  localparam int          MAXW   = 4096;
`ifdef PC_RX_DECODER_RESYNC_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] q_word = '0;
  logic        fifo_empty = 1'b1;
  logic        rd, start, valid, done, err;
  logic        ready = 1'b0;
  logic [15:0] len;
  logic [31:0] word;

  always #10 clk = ~clk;

  pc_rx_packet_decoder dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_fifo_output_word   (q_word),
    .i_fifo_is_empty_sig  (fifo_empty),
    .o_read_next_word_cmd (rd),
    .o_start_packet_sig   (start),
    .o_packet_len         (len),
    .o_payload_word       (word),
    .o_payload_valid      (valid),
    .i_payload_ready      (ready),
    .o_packet_done_sig    (done),
    .o_error_sig          (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: non-show-ahead, q updates the edge after rdreq.
  logic [31:0] fifo_q[$];
  logic [31:0] src_q[$];
  logic        rd_s = 1'b0;
  int          feed_pct = 100;

  always @(posedge clk) begin
    cyc++;
    if (rd_s && fifo_q.size() > 0) q_word <= fifo_q.pop_front();
    if (src_q.size() > 0 && $urandom_range(99) < feed_pct) fifo_q.push_back(src_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  int ready_mode = 1;  // 0 random, 1 high, 2 low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'($urandom_range(1));
        1:       ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  int          got_len[$];
  logic [31:0] got_pay[$];
  int          got_done = 0, got_err = 0, n_reads = 0;
  int          last_rd = -100, last_hs = -100;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word = '0;

  always @(negedge clk) begin
    rd_s = rd;
    if (!rst) begin
      if (start) begin got_len.push_back(int'(len)); check("start_latency", 64'(cyc - last_rd), 64'd2); end
      if (err)   begin got_err++;  check("error_latency", 64'(cyc - last_rd), 64'd2); end
      if (done)  begin got_done++; check("done_latency",  64'(cyc - last_hs), 64'd1); end
      if (prev_stall) begin
        check("hold_valid", 64'(valid), 64'd1);
        check("hold_word", 64'(word), 64'(prev_word));
      end
      if (valid && !ready) check("no_read_on_stall", 64'(rd), 64'd0);
      if (rd) begin check("read_nonempty", 64'(fifo_empty), 64'd0); last_rd = cyc; n_reads++; end
      if (valid && ready) begin got_pay.push_back(word); last_hs = cyc; end
      prev_stall = valid && !ready;
      prev_word  = word;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference model: packet-level scan of the word stream.
  int          exp_len[$];
  logic [31:0] exp_pay[$];
  int          exp_done, exp_err;

  task automatic model(input logic [31:0] w[$]);
    int i, n, plen, k;
    bit have_resync, aborted;
    exp_len.delete(); exp_pay.delete(); exp_done = 0; exp_err = 0;
    i = 0; n = w.size(); have_resync = 0;
    while (i < n) begin
      if (!have_resync) begin
        if (w[i] == RESYNC) have_resync = 1;
        i++;
        continue;
      end
      if (w[i] == RESYNC) begin i++; continue; end
      have_resync = 0;
      if (w[i] != MAGIC) begin exp_err++; i++; continue; end
      i++;
      if (i >= n) break;
      plen = int'(w[i][15:0]);
      i++;
      if (plen == 0 || plen > MAXW) begin exp_err++; continue; end
      exp_len.push_back(plen);
      k = 0; aborted = 0;
      while (k < plen && i < n) begin
        if (ABORT_EN && w[i] == RESYNC) begin exp_err++; aborted = 1; have_resync = 1; i++; break; end
        exp_pay.push_back(w[i]);
        i++; k++;
      end
      if (!aborted && k == plen) exp_done++;
    end
  endtask

  task automatic clear_got();
    got_len.delete(); got_pay.delete(); got_done = 0; got_err = 0;
  endtask

  task automatic wait_idle(input string name);
    int quiet, budget;
    quiet = 0; budget = 0;
    while (quiet < 6 && budget < 30000) begin
      @(negedge clk);
      budget++;
      if (src_q.size() == 0 && fifo_q.size() == 0 && !valid && !rd) quiet++;
      else quiet = 0;
    end
    if (quiet < 6) begin
      n_checks++; n_fail++;
      $display("FAIL %s_idle: got busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic wait_pay(input int n, input string name);
    int b;
    b = 0;
    while (got_pay.size() < n && b < 3000) begin @(negedge clk); b++; end
    if (got_pay.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL %s_wait: got %0d payload words, required %0d", name, got_pay.size(), n);
    end
  endtask

  task automatic compare(input string name);
    int m;
    check({name, "_packets"}, 64'(got_len.size()), 64'(exp_len.size()));
    m = (got_len.size() < exp_len.size()) ? got_len.size() : exp_len.size();
    for (int i = 0; i < m; i++) check({name, "_len"}, 64'(got_len[i]), 64'(exp_len[i]));
    check({name, "_words"}, 64'(got_pay.size()), 64'(exp_pay.size()));
    m = (got_pay.size() < exp_pay.size()) ? got_pay.size() : exp_pay.size();
    for (int i = 0; i < m; i++)
      if (got_pay[i] !== exp_pay[i]) begin check({name, "_word"}, 64'(got_pay[i]), 64'(exp_pay[i])); break; end
    check({name, "_done"}, 64'(got_done), 64'(exp_done));
    check({name, "_err"}, 64'(got_err), 64'(exp_err));
  endtask

  logic [31:0] stream[$];

  task automatic run_stream(input string name);
    model(stream);
    clear_got();
    foreach (stream[i]) src_q.push_back(stream[i]);
    wait_idle(name);
    compare(name);
    stream.delete();
  endtask

  function automatic logic [31:0] garbage();
    logic [31:0] g;
    do g = $urandom; while (g == RESYNC || g == MAGIC);
    return g;
  endfunction

  typedef struct {
    logic [31:0] hdr;
    bit          accept;
  } len_vec_t;

  len_vec_t    vecs[7];
  logic [31:0] snap[$];
  logic [31:0] p0, p1;
  int          rd_before, pay_before;

  initial begin
    vecs[0] = '{32'h0000_0003, 1'b1};
    vecs[1] = '{32'h0000_0000, 1'b0};
    vecs[2] = '{32'h0000_1001, 1'b0};
    vecs[3] = '{32'hFFFF_0002, 1'b1};
    vecs[4] = '{32'h0000_FFFF, 1'b0};
    vecs[5] = '{32'h0000_0001, 1'b1};
    vecs[6] = '{32'h0000_1000, 1'b1};

    src_q.push_back(32'h1111_1111);
    repeat (3) @(negedge clk);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_len", 64'(len), 64'd0);
    check("rst_word", 64'(word), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    wait_idle("post_reset");

    // Length header table.
    foreach (vecs[v]) begin
      stream.push_back(RESYNC); stream.push_back(MAGIC); stream.push_back(vecs[v].hdr);
      if (vecs[v].accept) begin
        for (int k = 0; k < int'(vecs[v].hdr[15:0]); k++) stream.push_back(32'hC000_0000 | (v << 16) | k);
      end else begin
        stream.push_back(32'hBAD0_0001); stream.push_back(32'hBAD0_0002);
      end
      run_stream("vec");
      check("vec_start", 64'(got_len.size()), 64'(vecs[v].accept));
      check("vec_error", 64'(got_err), 64'(!vecs[v].accept));
      if (vecs[v].accept) check("vec_len_port", 64'(len), 64'(vecs[v].hdr[15:0]));
    end

    // Bad magic, then MAGIC arrives while hunting.
    stream = '{RESYNC, 32'h1234_5678, MAGIC, 32'h0000_0003, 32'hAAAA_0001};
    run_stream("bad_magic");
    check("bad_magic_silent", 64'(got_pay.size()), 64'd0);

    // Ready held low mid-payload.
    stream = '{RESYNC, MAGIC, 32'h0000_0005, 32'h5000_0000, 32'h5000_0001, 32'h5000_0002,
               32'h5000_0003, 32'h5000_0004};
    model(stream);
    clear_got();
    foreach (stream[i]) src_q.push_back(stream[i]);
    stream.delete();
    wait_pay(2, "stall");
    ready_mode = 2;
    @(posedge clk); #2;
    repeat (3) @(negedge clk);
    rd_before = n_reads; pay_before = got_pay.size();
    repeat (10) @(negedge clk);
    check("stall_reads", 64'(n_reads - rd_before), 64'd0);
    check("stall_accepts", 64'(got_pay.size() - pay_before), 64'd0);
    check("stall_valid", 64'(valid), 64'd1);
    ready_mode = 1;
    wait_idle("stall");
    compare("stall");

    // RESYNC inside payload.
    stream = '{RESYNC, MAGIC, 32'h0000_0004, 32'h7000_0000, RESYNC, MAGIC, 32'h0000_0002,
               32'h7100_0000, 32'h7100_0001};
    run_stream("inpay");
    check("inpay_err", 64'(got_err), ABORT_EN ? 64'd1 : 64'd0);
    check("inpay_done", 64'(got_done), 64'd1);

    // Reset after 2 of 5 payload words.
    p0 = 32'hA000_0000; p1 = 32'hA000_0001;
    stream = '{RESYNC, MAGIC, 32'h0000_0005, p0, p1, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004,
               RESYNC, MAGIC, 32'h0000_0002, 32'hB000_0000, 32'hB000_0001};
    clear_got();
    foreach (stream[i]) src_q.push_back(stream[i]);
    stream.delete();
    wait_pay(2, "mid_rst");
    check("mid_rst_w0", 64'(got_pay[0]), 64'(p0));
    check("mid_rst_w1", 64'(got_pay[1]), 64'(p1));
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(valid), 64'd0);
    check("mid_rst_rd", 64'(rd), 64'd0);
    check("mid_rst_len", 64'(len), 64'd0);
    check("mid_rst_word", 64'(word), 64'd0);
    check("mid_rst_pulses", 64'({start, done, err}), 64'd0);
    snap = fifo_q;
    foreach (src_q[i]) snap.push_back(src_q[i]);
    model(snap);
    repeat (2) @(posedge clk);
    #2;
    clear_got();
    rst = 1'b0;
    wait_idle("after_rst");
    compare("after_rst");

    // Randomized framing with random ready and FIFO gaps.
    ready_mode = 0;
    feed_pct = 60;
    for (int blk = 0; blk < 3; blk++) begin
      for (int s = 0; s < 15; s++) begin
        case ($urandom_range(5))
          0: stream.push_back(garbage());
          1: begin stream.push_back(RESYNC); stream.push_back(garbage()); end
          2: begin
            stream.push_back(RESYNC); stream.push_back(MAGIC);
            stream.push_back(($urandom_range(1) == 0) ? 32'h0000_0000 : 32'h0000_1001 + $urandom_range(100));
          end
          default: begin
            int plen;
            plen = $urandom_range(1, 6);
            stream.push_back(RESYNC);
            if ($urandom_range(3) == 0) stream.push_back(RESYNC);
            stream.push_back(MAGIC);
            stream.push_back({16'($urandom), 16'(plen)});
            for (int k = 0; k < plen; k++)
              stream.push_back(($urandom_range(7) == 0) ? RESYNC : garbage());
          end
        endcase
      end
      run_stream("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: got no end of test, required finish within budget");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
